// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
package stopwatch_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned LAP_CNT_W = 4;

  typedef enum logic [STATE_W-1:0] {
    StIdle = 3'd0,
    StRun  = 3'd1,
    StStop = 3'd2,
    StLap  = 3'd3
  } state_t;

endpackage

// File: rtl/pb_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debounce, one-cycle press pulse.
module pb_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          blocked_q, blocked_d;
  logic          press_q, press_d;

  // Synchronizer is left out of reset so a button held through reset is seen as high.
  always_ff @(posedge clk) begin
    sync1_q <= btn_i;
    sync2_q <= sync1_q;
  end

  always_comb begin
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    // A press is only honoured once the button has been seen low after reset.
    blocked_d = blocked_q & sync2_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        press_d  = sync2_q & ~blocked_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      blocked_q <= 1'b1;
      press_q   <= 1'b0;
    end else begin
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      blocked_q <= blocked_d;
      press_q   <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced buttons drive run/stop/lap/clear and a tick prescaler.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned TICK_DIV        = 1
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 start_stop_i,
  input  logic                 lap_i,
  input  logic                 clear_i,
  output logic                 tick_o,
  output logic                 count_en_o,
  output logic                 count_clr_o,
  output logic                 lap_capture_o,
  output logic                 display_hold_o,
  output logic [STATE_W-1:0]   state_o,
  output logic [LAP_CNT_W-1:0] lap_cnt_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic ss_ev, lap_ev, clr_ev;

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk    (clk),
    .rst_i  (rst_i),
    .btn_i  (start_stop_i),
    .press_o(ss_ev)
  );

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk    (clk),
    .rst_i  (rst_i),
    .btn_i  (lap_i),
    .press_o(lap_ev)
  );

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk    (clk),
    .rst_i  (rst_i),
    .btn_i  (clear_i),
    .press_o(clr_ev)
  );

  state_t                 state_q, state_d;
  logic [LAP_CNT_W-1:0]   lap_cnt_q, lap_cnt_d;
  logic                   clr_q, clr_d;
  logic                   cap_q, cap_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   tick_q, tick_d;
  logic                   run_q, run_d;

  assign run_q = (state_q == StRun) || (state_q == StLap);
  assign run_d = (state_d == StRun) || (state_d == StLap);

  always_comb begin
    state_d   = state_q;
    lap_cnt_d = lap_cnt_q;
    clr_d     = 1'b0;
    cap_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_ev) begin
          clr_d     = 1'b1;
          lap_cnt_d = '0;
        end else if (ss_ev) begin
          state_d = StRun;
        end
      end
      StRun, StLap: begin
        if (ss_ev) begin
          state_d = StStop;
        end else if (lap_ev) begin
          state_d = StLap;
          cap_d   = 1'b1;
          if (lap_cnt_q != '1) lap_cnt_d = lap_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (clr_ev) begin
          state_d   = StIdle;
          clr_d     = 1'b1;
          lap_cnt_d = '0;
        end else if (ss_ev) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Advance only while timing before and after this edge, so the phase freezes across STOP.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (clr_d) begin
      presc_d = '0;
    end else if (run_q && run_d) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= StIdle;
      lap_cnt_q <= '0;
      clr_q     <= 1'b0;
      cap_q     <= 1'b0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lap_cnt_q <= lap_cnt_d;
      clr_q     <= clr_d;
      cap_q     <= cap_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
    end
  end

  assign tick_o         = tick_q;
  assign count_en_o     = run_q;
  assign count_clr_o    = clr_q;
  assign lap_capture_o  = cap_q;
  assign display_hold_o = (state_q == StLap);
  assign state_o        = state_q;
  assign lap_cnt_o      = lap_cnt_q;

endmodule
